// File: rtl/nios2_timer_cpu_mult_seq.sv
// Sequential signed/unsigned multiplier: one SLICE_W x SLICE_W partial product per cycle.
// Optional MULT_EARLY_ZERO_EN: a zero operand skips straight to DONE with a zero result.
module nios2_timer_cpu_mult_seq #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_a_signed,
  input  logic              in_b_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_lo,
  output logic [DATA_W-1:0] out_hi,
  output logic              busy
);

  localparam int S     = DATA_W / SLICE_W;
  localparam int ACC_W = 2 * DATA_W;
  localparam int IW    = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic              neg_q, neg_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [IW-1:0]     ia_q, ia_d, ib_q, ib_d;
  logic [DATA_W-1:0] out_lo_q, out_lo_d, out_hi_q, out_hi_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic              a_neg, b_neg;
  logic [SLICE_W-1:0] slice_a, slice_b;
  logic [ACC_W-1:0]  pp, res;

  always_comb begin
    state_d     = state_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    ia_d        = ia_q;
    ib_d        = ib_q;
    out_lo_d    = out_lo_q;
    out_hi_d    = out_hi_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;

    a_neg   = in_a_signed & in_a[DATA_W-1];
    b_neg   = in_b_signed & in_b[DATA_W-1];
    slice_a = SLICE_W'(mag_a_q >> (int'(ia_q) * SLICE_W));
    slice_b = SLICE_W'(mag_b_q >> (int'(ib_q) * SLICE_W));
    pp      = (ACC_W'(slice_a) * ACC_W'(slice_b)) << (SLICE_W * (int'(ia_q) + int'(ib_q)));
    // Magnitudes make negation a single step at the end; -0 wraps back to 0.
    res     = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_a_d    = a_neg ? (~in_a + DATA_W'(1)) : in_a;
          mag_b_d    = b_neg ? (~in_b + DATA_W'(1)) : in_b;
          neg_d      = a_neg ^ b_neg;
          acc_d      = '0;
          ia_d       = '0;
          ib_d       = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = MUL;
`ifdef MULT_EARLY_ZERO_EN
          if (in_a == '0 || in_b == '0) begin
            out_lo_d    = '0;
            out_hi_d    = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
`endif
        end
      end
      MUL: begin
        acc_d = acc_q + pp;
        if (ia_q == IW'(S - 1)) begin
          ia_d = '0;
          if (ib_q == IW'(S - 1)) state_d = FIX;
          else                    ib_d    = ib_q + IW'(1);
        end else begin
          ia_d = ia_q + IW'(1);
        end
      end
      FIX: begin
        out_lo_d    = res[DATA_W-1:0];
        out_hi_d    = res[ACC_W-1:DATA_W];
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      ia_q        <= '0;
      ib_q        <= '0;
      out_lo_q    <= '0;
      out_hi_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      ia_q        <= ia_d;
      ib_q        <= ib_d;
      out_lo_q    <= out_lo_d;
      out_hi_q    <= out_hi_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_lo    = out_lo_q;
  assign out_hi    = out_hi_q;
  assign busy      = busy_q;

endmodule
